jtgng_ram: RTL and testbench

JTGNG_RAM -- requirements
Module: jtgng_ram

---
 rtl/jtgng_ram.sv | 50 +++++
 tb/tb_jtgng_ram.sv | 138 +++++++++++++
 2 files changed

// File: rtl/jtgng_ram.sv
// Single-port synchronous RAM with a registered, read-first output port.
// Maps onto an inferred block RAM; only the output register is affected by rst.
module jtgng_ram #(
   parameter int dw = 8,
   parameter int aw = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic [aw-1:0] addr,
   input  logic [dw-1:0] data,
   input  logic          we,
   output logic [dw-1:0] q
);

   localparam int depth = 32'd1 << aw;

   logic [dw-1:0] mem_r [depth];
   logic [dw-1:0] q_r;
   logic          wr_en_s;

   // Write qualifier: reset blocks writes even while cen and we are high
   always_comb begin
      wr_en_s = 1'b0;
      if (!rst && cen && we) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Memory array write port, kept free of reset so it infers block RAM
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[addr] <= data;
      end
   end

   // Output register: read-first, so a write to the same address returns old data
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= {dw{1'b0}};
      end else if (cen) begin
         q_r <= mem_r[addr];
      end
   end

   assign q = q_r;

endmodule

// File: tb/tb_jtgng_ram.sv
// Scoreboard bench for jtgng_ram (aw=13): driver queues expected read data,
// a negedge monitor pops and compares after each checked edge.
module tb_jtgng_ram;

   logic        clk;
   logic        rst;
   logic        cen;
   logic [12:0] addr;
   logic [7:0]  data;
   logic        we;
   logic [7:0]  q;

   logic        chk_vld;
   logic        chk_d;
   logic [7:0]  exp_q[$];
   string       name_q[$];
   int          errors;
   int          checks;

   jtgng_ram #(.dw(8), .aw(13)) dut (
      .clk  (clk),
      .rst  (rst),
      .cen  (cen),
      .addr (addr),
      .data (data),
      .we   (we),
      .q    (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Marks which edges produced a q value to compare
   always @(posedge clk) chk_d <= chk_vld;

   // Monitor: compare q mid-cycle after every checked edge
   always @(negedge clk) begin
      logic [7:0] e;
      string      n;
      if (chk_d === 1'b1) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_empty: q=%h with no expected value queued", q);
         end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (q !== e) begin
               errors = errors + 1;
               $display("FAIL %s: q=%h expected %h", n, q, e);
            end
         end
      end
   end

   task automatic cyc(input logic r, input logic c, input logic w,
                      input logic [12:0] a, input logic [7:0] d,
                      input logic chk, input logic [7:0] e, input string nm);
      @(negedge clk);
      rst     = r;
      cen     = c;
      we      = w;
      addr    = a;
      data    = d;
      chk_vld = chk;
      if (chk) begin
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
   endtask

   initial begin
      logic [12:0] a;
      logic [7:0]  pat;
      errors  = 0;
      checks  = 0;
      rst     = 1'b1;
      cen     = 1'b0;
      we      = 1'b0;
      addr    = 13'h0000;
      data    = 8'h00;
      chk_vld = 1'b0;

      // Reset clears q, independent of cen
      cyc(1'b1, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 8'h00, "reset_q_cen0");
      cyc(1'b1, 1'b1, 1'b0, 13'h0000, 8'h00, 1'b1, 8'h00, "reset_q_cen1");

      // Boundary addresses
      cyc(1'b0, 1'b1, 1'b1, 13'h0000, 8'hA5, 1'b0, 8'h00, "");
      cyc(1'b0, 1'b1, 1'b1, 13'h1FFF, 8'h3C, 1'b0, 8'h00, "");
      cyc(1'b0, 1'b1, 1'b0, 13'h0000, 8'h00, 1'b1, 8'hA5, "read_addr_0");
      cyc(1'b0, 1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b1, 8'h3C, "read_addr_last");

      // Read-during-write returns old contents
      cyc(1'b0, 1'b1, 1'b1, 13'h0005, 8'h11, 1'b0, 8'h00, "");
      cyc(1'b0, 1'b1, 1'b1, 13'h0005, 8'h22, 1'b1, 8'h11, "rdw_old_data");
      cyc(1'b0, 1'b1, 1'b0, 13'h0005, 8'h00, 1'b1, 8'h22, "rdw_new_data");

      // cen=0 blocks writes and holds q
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 13'h0005, 8'hFF, 1'b1, 8'h22, "cen0_hold");
      end
      cyc(1'b0, 1'b0, 1'b0, 13'h0000, 8'hFF, 1'b1, 8'h22, "cen0_hold_addr_change");
      cyc(1'b0, 1'b1, 1'b0, 13'h0005, 8'h00, 1'b1, 8'h22, "cen0_no_write");

      // Reset suppresses writes and keeps memory contents
      cyc(1'b0, 1'b1, 1'b1, 13'h0009, 8'h77, 1'b0, 8'h00, "");
      cyc(1'b1, 1'b1, 1'b1, 13'h0009, 8'h00, 1'b1, 8'h00, "rst_q_zero_1");
      cyc(1'b1, 1'b1, 1'b1, 13'h0009, 8'h00, 1'b1, 8'h00, "rst_q_zero_2");
      cyc(1'b0, 1'b1, 1'b0, 13'h0009, 8'h00, 1'b1, 8'h77, "mem_kept_after_rst");
      cyc(1'b0, 1'b1, 1'b0, 13'h0005, 8'h00, 1'b1, 8'h22, "mem5_kept_after_rst");

      // Full-depth fill and readback
      for (int i = 0; i < 8192; i++) begin
         a   = 13'(i);
         pat = a[7:0] ^ {3'b000, a[12:8]};
         cyc(1'b0, 1'b1, 1'b1, a, pat, 1'b0, 8'h00, "");
      end
      for (int i = 0; i < 8192; i++) begin
         a   = 13'(i);
         pat = a[7:0] ^ {3'b000, a[12:8]};
         cyc(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b1, pat, "fill_readback");
      end

      cyc(1'b0, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 8'h00, "");
      repeat (3) @(negedge clk);

      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
